// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// INTC_SYNC_EN adds a 2-flop synchronizer per interrupt line.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

`ifdef INTC_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  // Global-enable sits just above the mask bits in cfg_wd/cfg_rd.
  function automatic int gie_bit(input int n_int);
    return n_int;
  endfunction

endpackage

// File: rtl/int_ctrl_edge_det.sv
// Per-line rising-edge detector, optional 2-flop synchronizer (INTC_SYNC_EN).
// The pulse is suppressed until the sample pipeline has refilled after reset.
module int_edge_det
  import int_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic int_i,
  output logic pulse_o
);

  localparam logic [1:0] PRIME_N = 2'(SYNC_STAGES + 1);

  logic       samp;
  logic       hist_q, hist_d;
  logic [1:0] prime_q, prime_d;

`ifdef INTC_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], int_i};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign samp = sync_q[1];
`else
  assign samp = int_i;
`endif

  // A line already high at reset release loads history without firing.
  always_comb begin
    hist_d  = samp;
    prime_d = (prime_q == PRIME_N) ? prime_q : prime_q + 2'd1;
  end

  assign pulse_o = (prime_q == PRIME_N) & samp & ~hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= 1'b0;
      prime_q <= '0;
    end else begin
      hist_q  <= hist_d;
      prime_q <= prime_d;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge-latched pending bits, fixed lowest-index
// priority, non-nesting IDLE/REQ/SERVICE handshake. Option macro: INTC_SYNC_EN.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          N_INT      = 4,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
  localparam int         IDW        = (N_INT > 1) ? $clog2(N_INT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INT-1:0] INT,
  input  logic             cfg_we,
  input  logic [N_INT:0]   cfg_wd,
  output logic [N_INT:0]   cfg_rd,
  input  logic             irq_ack,
  input  logic             eret,
  output logic             irq,
  output logic [IDW-1:0]   irq_id,
  output logic [31:0]      irq_addr,
  output logic [N_INT-1:0] pending,
  output logic             in_service
);

  localparam int GIE = gie_bit(N_INT);

  state_e           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d, win;
  logic [N_INT-1:0] pend_q, pend_d, edge_pulse, cand, clr;
  logic [N_INT:0]   cfg_q, cfg_d;

  for (genvar i = 0; i < N_INT; i++) begin : g_line
    int_edge_det u_edge (
      .clk    (clk),
      .rst    (rst),
      .int_i  (INT[i]),
      .pulse_o(edge_pulse[i])
    );
  end

  always_comb begin
    cand = pend_q & cfg_q[N_INT-1:0] & {N_INT{cfg_q[GIE]}};
    win  = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (cand[i]) win = IDW'(i);
    end
  end

  // irq_id is only loaded on IDLE->REQ, so it stays frozen through REQ/SERVICE.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          state_d = ST_REQ;
          id_d    = win;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_SERVICE;
          clr     = N_INT'(1) << id_q;
        end
      end
      ST_SERVICE: begin
        if (eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = (pend_q & ~clr) | edge_pulse;
    cfg_d  = cfg_we ? cfg_wd : cfg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      cfg_q   <= cfg_d;
    end
  end

  assign irq        = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign irq_id     = id_q;
  assign irq_addr   = VEC_BASE + 32'(id_q) * VEC_STRIDE;
  assign pending    = pend_q;
  assign cfg_rd     = cfg_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl (default build): directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  int_r;
  logic        cfg_we;
  logic [4:0]  cfg_wd;
  logic [4:0]  cfg_rd;
  logic        irq_ack;
  logic        eret;
  logic        irq;
  logic [1:0]  irq_id;
  logic [31:0] irq_addr;
  logic [3:0]  pending;
  logic        in_service;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [3:0] m_pend, m_mask, m_hist;
  logic       m_gie, m_req, m_srv, m_primed;
  int         m_id;

  int_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (int_r),
    .cfg_we    (cfg_we),
    .cfg_wd    (cfg_wd),
    .cfg_rd    (cfg_rd),
    .irq_ack   (irq_ack),
    .eret      (eret),
    .irq       (irq),
    .irq_id    (irq_id),
    .irq_addr  (irq_addr),
    .pending   (pending),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] edges, cand, clr, lowest;
    if (rst) begin
      m_pend = '0; m_mask = '0; m_hist = '0;
      m_gie = 1'b0; m_req = 1'b0; m_srv = 1'b0; m_primed = 1'b0; m_id = 0;
      return;
    end
    edges = m_primed ? (int_r & ~m_hist) : 4'b0;
    cand  = m_pend & m_mask & {4{m_gie}};
    clr   = '0;
    if (!m_req && !m_srv) begin
      if (cand != 0) begin
        lowest = cand & (~cand + 4'd1);
        m_id   = $clog2(lowest);
        m_req  = 1'b1;
      end
    end else if (m_req) begin
      if (irq_ack) begin
        clr[m_id] = 1'b1;
        m_req = 1'b0;
        m_srv = 1'b1;
      end
    end else if (eret) begin
      m_srv = 1'b0;
    end
    m_pend = (m_pend & ~clr) | edges;
    if (cfg_we) {m_gie, m_mask} = cfg_wd;
    m_hist   = int_r;
    m_primed = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_req});
    chk("in_service", {31'd0, in_service}, {31'd0, m_srv});
    chk("irq_id", {30'd0, irq_id}, m_id);
    chk("irq_addr", irq_addr, 32'h100 + m_id * 32'h10);
    chk("pending", {28'd0, pending}, {28'd0, m_pend});
    chk("cfg_rd", {27'd0, cfg_rd}, {27'd0, m_gie, m_mask});
  endtask

  task automatic pulse(input logic [3:0] m);
    int_r = m;  tick();
    int_r = '0; tick();
  endtask

  task automatic cfg(input logic [4:0] wd);
    cfg_we = 1'b1; cfg_wd = wd; tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; int_r = '0; cfg_we = 1'b0; cfg_wd = '0; irq_ack = 1'b0; eret = 1'b0;
    tick(); tick();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pend", {28'd0, pending}, 32'd0);
    chk("rst_cfg", {27'd0, cfg_rd}, 32'd0);
    chk("rst_insvc", {31'd0, in_service}, 32'd0);
    chk("rst_id", {30'd0, irq_id}, 32'd0);
    rst = 1'b0;
    tick();

    // single line, two-clock latency and vector address
    cfg(5'b1_1111);
    pulse(4'b0100);
    chk("t35_irq", {31'd0, irq}, 32'd1);
    chk("t35_id", {30'd0, irq_id}, 32'd2);
    chk("t35_addr", irq_addr, 32'h0000_0120);
    do_ack(); do_eret();

    // simultaneous edges: lowest index first, the other after eret
    pulse(4'b1010);
    chk("t36_id1", {30'd0, irq_id}, 32'd1);
    chk("t36_addr1", irq_addr, 32'h0000_0110);
    do_ack();
    chk("t36_svc_irq", {31'd0, irq}, 32'd0);
    chk("t36_svc_pend", {28'd0, pending}, 32'h8);
    do_eret(); tick();
    chk("t36_irq3", {31'd0, irq}, 32'd1);
    chk("t36_id3", {30'd0, irq_id}, 32'd3);
    chk("t36_addr3", irq_addr, 32'h0000_0130);
    do_ack(); do_eret();

    // masked line stays pending until unmasked
    cfg(5'b1_1110);
    pulse(4'b0001);
    chk("t37_pend", {28'd0, pending}, 32'h1);
    chk("t37_noirq", {31'd0, irq}, 32'd0);
    cfg(5'b1_1111); tick();
    chk("t37_irq", {31'd0, irq}, 32'd1);
    chk("t37_id", {30'd0, irq_id}, 32'd0);
    do_ack(); do_eret();

    // gie off holds request back
    cfg(5'b0_1111);
    pulse(4'b0010); tick();
    chk("t38_noirq", {31'd0, irq}, 32'd0);
    chk("t38_pend", {28'd0, pending}, 32'h2);
    cfg(5'b1_1111); tick();
    chk("t38_irq", {31'd0, irq}, 32'd1);
    chk("t38_id", {30'd0, irq_id}, 32'd1);
    do_ack(); do_eret();

    // edge coincident with ack of the same line: set wins
    pulse(4'b0100);
    irq_ack = 1'b1; int_r = 4'b0100; tick();
    irq_ack = 1'b0; int_r = '0;
    chk("t39_pend", {28'd0, pending}, 32'h4);
    chk("t39_insvc", {31'd0, in_service}, 32'd1);
    do_eret(); tick();
    chk("t39_irq", {31'd0, irq}, 32'd1);
    chk("t39_id", {30'd0, irq_id}, 32'd2);
    do_ack(); do_eret();

    // reset during service dominates cfg writes and edges
    pulse(4'b0001); do_ack();
    pulse(4'b1000);
    rst = 1'b1; int_r = 4'b1111; cfg_we = 1'b1; cfg_wd = 5'b1_1111; tick();
    cfg_we = 1'b0;
    chk("t40_irq", {31'd0, irq}, 32'd0);
    chk("t40_insvc", {31'd0, in_service}, 32'd0);
    chk("t40_pend", {28'd0, pending}, 32'd0);
    chk("t40_cfg", {27'd0, cfg_rd}, 32'd0);
    // lines held high across reset release must not latch
    rst = 1'b0; tick(); tick(); tick();
    chk("t31_pend", {28'd0, pending}, 32'd0);
    int_r = '0; tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      int_r   = int_r ^ (4'($urandom) & 4'($urandom));
      cfg_we  = ($urandom_range(0, 7) == 0);
      cfg_wd  = {($urandom_range(0, 3) != 0), 4'($urandom)};
      irq_ack = ($urandom_range(0, 2) == 0);
      eret    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
